// File: rtl/debounce_4input_pkg.sv
// Shared constants and types for the four-channel input debouncer.
package debounce_defs;

    // Default build-time settings.
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 16;

    // Channel count and the AND-stage input each channel feeds.
    localparam int NUM_CH = 4;
    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int CH_C   = 2;
    localparam int CH_D   = 3;

    // One bit per channel, bit CH_A first.
    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage : debounce_defs

// File: rtl/debounce_4input_if.sv
// Signal bundle between the raw switch inputs and the debounced outputs.
interface debounce_4input_if;
    import debounce_defs::*;

    ch_vec_t in_raw;
    ch_vec_t out_clean;
    ch_vec_t out_rise;
    ch_vec_t out_fall;
    logic    all_stable;

    // Master drives the raw inputs and consumes the conditioned outputs.
    modport master (
        output in_raw,
        input  out_clean,
        input  out_rise,
        input  out_fall,
        input  all_stable
    );

    // Slave is the debouncer itself.
    modport slave (
        input  in_raw,
        output out_clean,
        output out_rise,
        output out_fall,
        output all_stable
    );

endinterface : debounce_4input_if

// File: rtl/debounce_4input_1ch.sv
// One debounce channel: synchroniser chain, persistence counter, clean level
// register and registered rise/fall pulses.
module debounce_1ch
    import debounce_defs::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic stable_o
);

    // Last count value before a differing level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign synced = sync_q[SYNC_STAGES-1];

    // Plain flop chain into the clock domain; nothing sits between stages.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Count consecutive mismatching edges; accept the new level on the last one.
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced != clean_q) begin
            if (cnt_q == CNT_MAX) begin
                clean_d = synced;
                rise_d  = synced;
                fall_d  = ~synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter, clean level and edge pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o  = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign stable_o = (synced == clean_q) && (cnt_q == '0);

endmodule : debounce_1ch

// File: rtl/debounce_4input.sv
// Four-channel input conditioner feeding the 4-input AND stage (bit 0 = a).
module debounce_4input
    import debounce_defs::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    debounce_4input_if.slave   bus
);

    ch_vec_t clean_w;
    ch_vec_t rise_w;
    ch_vec_t fall_w;
    ch_vec_t stable_w;
    logic    all_stable_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_1ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (bus.in_raw[i]),
            .clean_o  (clean_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i]),
            .stable_o (stable_w[i])
        );
    end

    // Register the AND of per-channel stability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_stable_q <= 1'b0;
        else        all_stable_q <= &stable_w;
    end

    assign bus.out_clean  = clean_w;
    assign bus.out_rise   = rise_w;
    assign bus.out_fall   = fall_w;
    assign bus.all_stable = all_stable_q;

endmodule : debounce_4input

// File: tb/tb_debounce_4input.sv
// Self-checking bench for debounce_4input: directed scenarios plus random
// traffic compared against a sliding-window reference model.
module tb_debounce_4input;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    debounce_4input_if bus ();

    debounce_4input #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples travel SYNC edges before they are seen by
    // the counter; a level is accepted when the last DEB seen values all
    // differ from the current clean level.
    logic [3:0] rq [$];
    logic [3:0] win [$];
    logic [3:0] m_clean, m_rise, m_fall;
    logic       m_stable;

    function automatic int trail(input int ch);
        int n = 0;
        for (int j = win.size() - 1; j >= 0; j--) begin
            if (win[j][ch] == m_clean[ch]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        rq.delete();
        win.delete();
        for (int j = 0; j < SYNC; j++) rq.push_back(4'b0000);
        m_clean  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_stable = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] s;
        logic       st;
        s = rq.pop_front();
        rq.push_back(raw);
        st = 1'b1;
        for (int ch = 0; ch < 4; ch++)
            if (s[ch] != m_clean[ch] || trail(ch) != 0) st = 1'b0;
        win.push_back(s);
        if (win.size() > DEB) void'(win.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (trail(ch) >= DEB) begin
                m_rise[ch]  = s[ch];
                m_fall[ch]  = ~s[ch];
                m_clean[ch] = s[ch];
            end
        end
        m_stable = st;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one raw value across one rising edge and compare against the model.
    task automatic step(input logic [3:0] raw);
        bus.in_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check("model_clean",  bus.out_clean,        m_clean);
        check("model_rise",   bus.out_rise,         m_rise);
        check("model_fall",   bus.out_fall,         m_fall);
        check("model_stable", {3'b000, bus.all_stable}, {3'b000, m_stable});
    endtask

    // Asynchronous reset pulse lasting about one clock.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_clean",  bus.out_clean, 4'b0000);
        check("rst_rise",   bus.out_rise,  4'b0000);
        check("rst_fall",   bus.out_fall,  4'b0000);
        check("rst_stable", {3'b000, bus.all_stable}, 4'b0000);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic settle(input logic [3:0] raw, input int n);
        for (int k = 0; k < n; k++) step(raw);
    endtask

    initial begin
        logic [3:0] cur;
        int         n_rise;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.in_raw = 4'b0000;
        model_reset();

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("por_clean",  bus.out_clean, 4'b0000);
        check("por_stable", {3'b000, bus.all_stable}, 4'b0000);
        #3;
        rst_n = 1'b1;
        step(4'b0000);
        check("idle_stable", {3'b000, bus.all_stable}, 4'b0001);
        settle(4'b0000, 3);

        // Reset in the middle of a count: no rise may appear afterwards.
        settle(4'b0001, 3);
        reset_pulse();
        for (int k = 0; k < 8; k++) begin
            step(4'b0000);
            check("midrst_rise", bus.out_rise, 4'b0000);
            check("midrst_clean", bus.out_clean, 4'b0000);
        end

        // Clean step on channel a; step k is edge k.
        for (int k = 0; k < 8; k++) begin
            step(4'b0001);
            if (k == 4) check("step_clean_e4", bus.out_clean, 4'b0000);
            if (k == 5) begin
                check("step_clean_e5", bus.out_clean, 4'b0001);
                check("step_rise_e5",  bus.out_rise,  4'b0001);
            end
            if (k == 6) check("step_rise_e6", bus.out_rise, 4'b0000);
            if (k >= 2 && k <= 5) check("step_stable_low", {3'b000, bus.all_stable}, 4'b0000);
            if (k >= 6) check("step_stable_high", {3'b000, bus.all_stable}, 4'b0001);
        end
        settle(4'b0000, 10);

        // Glitch of three sampling edges on channel c is rejected.
        for (int k = 0; k < 11; k++) begin
            step(k < 3 ? 4'b0100 : 4'b0000);
            check("glitch_clean", bus.out_clean, 4'b0000);
            check("glitch_rise",  bus.out_rise,  4'b0000);
        end

        // Four sampling edges on channel c is the minimum accepted pulse.
        for (int k = 0; k < 12; k++) begin
            step(k < 4 ? 4'b0100 : 4'b0000);
            if (k == 5) begin
                check("minp_clean_e5", bus.out_clean, 4'b0100);
                check("minp_rise_e5",  bus.out_rise,  4'b0100);
            end
            if (k == 8) check("minp_fall_e8", bus.out_fall, 4'b0000);
            if (k == 9) begin
                check("minp_fall_e9",  bus.out_fall,  4'b0100);
                check("minp_clean_e9", bus.out_clean, 4'b0000);
            end
        end
        settle(4'b0000, 4);

        // Bounce on channel d, settling high; final 0->1 sample is edge 4.
        n_rise = 0;
        for (int k = 0; k < 14; k++) begin
            step((k == 1 || k == 3) ? 4'b0000 : 4'b1000);
            n_rise += int'(bus.out_rise[3]);
            if (k == 8) check("bounce_clean_e8", bus.out_clean, 4'b0000);
            if (k == 9) check("bounce_clean_e9", bus.out_clean, 4'b1000);
        end
        check("bounce_rise_count", 4'(n_rise), 4'd1);
        settle(4'b0000, 10);

        // All four channels rise together.
        for (int k = 0; k < 7; k++) begin
            step(4'b1111);
            if (k == 4) check("simul_clean_e4", bus.out_clean, 4'b0000);
            if (k == 5) begin
                check("simul_clean_e5", bus.out_clean, 4'b1111);
                check("simul_rise_e5",  bus.out_rise,  4'b1111);
                check("simul_and_e5",   {3'b000, &bus.out_clean}, 4'b0001);
            end
        end
        settle(4'b0000, 10);

        // Random traffic, biased toward holding each bit, with one reset.
        cur = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(3) == 0) cur[ch] = ~cur[ch];
            if (i == 200) reset_pulse();
            step(cur);
            check("rand_excl", bus.out_rise & bus.out_fall, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debounce_4input
